// File: rtl/muldiv_pkg.sv
// Operation encoding, station states and decode helpers shared by the
// multiply/divide reservation station and its datapath step.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    WAIT_OPERANDS = 2'd1,
    COMPUTE       = 2'd2,
    DONE          = 2'd3
  } station_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    case (op)
      OP_REM, OP_REMU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_a(input muldiv_op_t op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic wants_high(input muldiv_op_t op);
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step (acc:quo shifts right)
// or restoring divide step (acc:quo shifts left, quotient bit enters quo).
module muldiv_step #(
  parameter int SIZE  = 32,
  parameter int IDX_W = 6
) (
  input  logic             is_div,
  input  logic [SIZE-1:0]  operand,
  input  logic [SIZE-1:0]  acc_in,
  input  logic [SIZE-1:0]  quo_in,
  input  logic [IDX_W-1:0] idx_in,
  output logic [SIZE-1:0]  acc_out,
  output logic [SIZE-1:0]  quo_out,
  output logic [IDX_W-1:0] idx_out
);

  logic [SIZE:0] sum_s;
  logic [SIZE:0] trial_s;

  // Select the multiply or divide update; trial_s[SIZE] set means the subtract underflowed.
  always_comb begin
    sum_s   = {1'b0, acc_in} + (quo_in[0] ? {1'b0, operand} : {(SIZE+1){1'b0}});
    trial_s = {acc_in, quo_in[SIZE-1]} - {1'b0, operand};
    idx_out = idx_in + {{(IDX_W-1){1'b0}}, 1'b1};
    if (!is_div) begin
      acc_out = sum_s[SIZE:1];
      quo_out = {sum_s[0], quo_in[SIZE-1:1]};
    end else if (!trial_s[SIZE]) begin
      acc_out = trial_s[SIZE-1:0];
      quo_out = {quo_in[SIZE-2:0], 1'b1};
    end else begin
      acc_out = {acc_in[SIZE-2:0], quo_in[SIZE-1]};
      quo_out = {quo_in[SIZE-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_station.sv
// Multiply/divide reservation station: captures operands (preload or bus snoop),
// runs ITERATIONS_PER_CYCLE datapath steps per clock and holds the result until released.
module muldiv_station import muldiv_pkg::*; #(
  parameter int SIZE                 = 32,
  parameter int ITERATIONS_PER_CYCLE = 4,
  parameter int STATION_INDEX_SIZE   = 1,
  parameter int BUS_COUNT            = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  set_occupied,
  input  logic                                  reset_occupied,
  input  muldiv_op_t                            operation,
  input  logic                                  preload_a_value,
  input  logic                                  preload_b_value,
  input  logic [STATION_INDEX_SIZE-1:0]         a_source,
  input  logic [STATION_INDEX_SIZE-1:0]         b_source,
  input  logic [SIZE-1:0]                       preloaded_a_value,
  input  logic [SIZE-1:0]                       preloaded_b_value,
  input  logic [BUS_COUNT-1:0]                  bus_asserted,
  input  logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source,
  input  logic [SIZE*BUS_COUNT-1:0]             bus_value,
  output logic                                  occupied,
  output logic                                  result_ready,
  output logic [SIZE-1:0]                       result
);

  localparam int TW    = STATION_INDEX_SIZE;
  localparam int IPC   = ITERATIONS_PER_CYCLE;
  localparam int IDX_W = $clog2(SIZE) + 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE);
  localparam logic [SIZE-1:0]  ZERO     = {SIZE{1'b0}};
  localparam logic [SIZE-1:0]  ONES     = {SIZE{1'b1}};
  localparam logic [SIZE-1:0]  MIN_VAL  = {1'b1, {(SIZE-1){1'b0}}};

  // Lowest-indexed matching bus wins: scan downwards so the last hit written is the lowest.
  function automatic logic [SIZE:0] snoop(
    input logic [TW-1:0]           tag,
    input logic [BUS_COUNT-1:0]    valid,
    input logic [TW*BUS_COUNT-1:0] tags,
    input logic [SIZE*BUS_COUNT-1:0] values
  );
    logic [SIZE:0] hit;
    hit = {(SIZE+1){1'b0}};
    for (int i = BUS_COUNT - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i*TW +: TW] == tag)) hit = {1'b1, values[i*SIZE +: SIZE]};
    end
    return hit;
  endfunction

  station_state_t   state_r, state_n;
  muldiv_op_t       op_r, op_n;
  logic [SIZE-1:0]  a_r, a_n, b_r, b_n;
  logic             a_have_r, a_have_n, b_have_r, b_have_n;
  logic [TW-1:0]    a_tag_r, a_tag_n, b_tag_r, b_tag_n;
  logic [SIZE-1:0]  acc_r, acc_n, quo_r, quo_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [SIZE-1:0]  result_r, result_n;
  logic             occupied_r, ready_r;

  logic [SIZE:0]    snoop_a_s, snoop_b_s;
  logic             sign_a_s, sign_b_s, neg_s, special_s;
  logic [SIZE-1:0]  mag_a_s, mag_b_s, special_val_s, computed_s;
  logic [2*SIZE-1:0] prod_s;

  assign snoop_a_s = snoop(set_occupied ? a_source : a_tag_r, bus_asserted, bus_source, bus_value);
  assign snoop_b_s = snoop(set_occupied ? b_source : b_tag_r, bus_asserted, bus_source, bus_value);

  assign sign_a_s = is_signed_a(op_r) & a_r[SIZE-1];
  assign sign_b_s = is_signed_b(op_r) & b_r[SIZE-1];
  assign neg_s    = sign_a_s ^ sign_b_s;
  assign mag_a_s  = sign_a_s ? (ZERO - a_r) : a_r;
  assign mag_b_s  = sign_b_s ? (ZERO - b_r) : b_r;

  // Divide by zero and signed MIN / -1 bypass the iterative datapath.
  always_comb begin
    special_s = is_div(op_r) &&
                ((b_r == ZERO) || (is_signed_b(op_r) && (a_r == MIN_VAL) && (b_r == ONES)));
    if (b_r == ZERO) begin
      special_val_s = is_rem(op_r) ? a_r : ONES;
    end else begin
      special_val_s = is_rem(op_r) ? ZERO : MIN_VAL;
    end
  end

  logic [SIZE-1:0]  acc_c [IPC+1];
  logic [SIZE-1:0]  quo_c [IPC+1];
  logic [IDX_W-1:0] idx_c [IPC+1];

  assign acc_c[0] = (idx_r == IDX_ZERO) ? ZERO : acc_r;
  assign quo_c[0] = (idx_r == IDX_ZERO) ? mag_a_s : quo_r;
  assign idx_c[0] = idx_r;

  for (genvar g = 0; g < IPC; g++) begin : g_chain
    muldiv_step #(.SIZE(SIZE), .IDX_W(IDX_W)) u_step (
      .is_div  (is_div(op_r)),
      .operand (mag_b_s),
      .acc_in  (acc_c[g]),
      .quo_in  (quo_c[g]),
      .idx_in  (idx_c[g]),
      .acc_out (acc_c[g+1]),
      .quo_out (quo_c[g+1]),
      .idx_out (idx_c[g+1])
    );
  end

  // Sign fix-up of the finished magnitude result and half selection.
  always_comb begin
    prod_s = neg_s ? ({2*SIZE{1'b0}} - {acc_c[IPC], quo_c[IPC]}) : {acc_c[IPC], quo_c[IPC]};
    if (!is_div(op_r)) begin
      computed_s = wants_high(op_r) ? prod_s[2*SIZE-1:SIZE] : prod_s[SIZE-1:0];
    end else if (is_rem(op_r)) begin
      computed_s = sign_a_s ? (ZERO - acc_c[IPC]) : acc_c[IPC];
    end else begin
      computed_s = neg_s ? (ZERO - quo_c[IPC]) : quo_c[IPC];
    end
  end

  // Next-state and datapath update; issue overrides release, both override the FSM.
  always_comb begin
    state_n  = state_r;
    op_n     = op_r;
    a_n      = a_r;
    b_n      = b_r;
    a_have_n = a_have_r;
    b_have_n = b_have_r;
    a_tag_n  = a_tag_r;
    b_tag_n  = b_tag_r;
    acc_n    = acc_r;
    quo_n    = quo_r;
    idx_n    = idx_r;
    result_n = result_r;
    case (state_r)
      IDLE: state_n = IDLE;
      WAIT_OPERANDS: begin
        if (!a_have_r && snoop_a_s[SIZE]) begin
          a_n      = snoop_a_s[SIZE-1:0];
          a_have_n = 1'b1;
        end else begin
          a_n = a_r;
        end
        if (!b_have_r && snoop_b_s[SIZE]) begin
          b_n      = snoop_b_s[SIZE-1:0];
          b_have_n = 1'b1;
        end else begin
          b_n = b_r;
        end
        state_n = (a_have_n && b_have_n) ? COMPUTE : WAIT_OPERANDS;
      end
      COMPUTE: begin
        if ((idx_r == IDX_ZERO) && special_s) begin
          result_n = special_val_s;
          state_n  = DONE;
        end else begin
          acc_n = acc_c[IPC];
          quo_n = quo_c[IPC];
          idx_n = idx_c[IPC];
          if (idx_c[IPC] == LAST_IDX) begin
            result_n = computed_s;
            state_n  = DONE;
          end else begin
            state_n = COMPUTE;
          end
        end
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (set_occupied) begin
      op_n     = operation;
      a_tag_n  = a_source;
      b_tag_n  = b_source;
      a_have_n = preload_a_value | snoop_a_s[SIZE];
      b_have_n = preload_b_value | snoop_b_s[SIZE];
      a_n      = preload_a_value ? preloaded_a_value : snoop_a_s[SIZE-1:0];
      b_n      = preload_b_value ? preloaded_b_value : snoop_b_s[SIZE-1:0];
      idx_n    = IDX_ZERO;
      result_n = ZERO;
      state_n  = (a_have_n && b_have_n) ? COMPUTE : WAIT_OPERANDS;
    end else if (reset_occupied) begin
      a_have_n = 1'b0;
      b_have_n = 1'b0;
      idx_n    = IDX_ZERO;
      result_n = ZERO;
      state_n  = IDLE;
    end else begin
      result_n = result_n;
    end
  end

  // State and output registers; everything clears while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      op_r       <= OP_MUL;
      a_r        <= ZERO;
      b_r        <= ZERO;
      a_have_r   <= 1'b0;
      b_have_r   <= 1'b0;
      a_tag_r    <= {TW{1'b0}};
      b_tag_r    <= {TW{1'b0}};
      acc_r      <= ZERO;
      quo_r      <= ZERO;
      idx_r      <= IDX_ZERO;
      result_r   <= ZERO;
      occupied_r <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      op_r       <= op_n;
      a_r        <= a_n;
      b_r        <= b_n;
      a_have_r   <= a_have_n;
      b_have_r   <= b_have_n;
      a_tag_r    <= a_tag_n;
      b_tag_r    <= b_tag_n;
      acc_r      <= acc_n;
      quo_r      <= quo_n;
      idx_r      <= idx_n;
      result_r   <= result_n;
      occupied_r <= (state_n != IDLE);
      ready_r    <= (state_n == DONE);
    end
  end

  assign occupied     = occupied_r;
  assign result_ready = ready_r;
  assign result       = result_r;

endmodule

// File: doc/muldiv_station.md
# muldiv_station

Parametrised multiply/divide reservation station for the out-of-order RISC-V core. It accepts one M-extension operation per occupancy and captures missing operands by snooping the result buses. It then runs an iterative shift-add or restoring-divide datapath and holds the result until the scheduler releases it. It supersedes the fixed-32-bit multiplier station: it is width-generic, implements all eight M-extension ops including RISC-V divide-by-zero and overflow semantics, and never loses a same-cycle bus wakeup.

## Interface
- SIZE, 32, operand/result width; must be ≥ 4 and even
- ITERATIONS_PER_CYCLE, 4, datapath steps per clock; must divide SIZE
- STATION_INDEX_SIZE, 1, width of producer tags
- BUS_COUNT, 1, number of snooped result buses
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- set_occupied  in  1  issue strobe; latches op and operands
- reset_occupied  in  1  release/flush strobe
- operation  in  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- preload_a_value, preload_b_value  in  1  operand valid at issue
- a_source, b_source  in  STATION_INDEX_SIZE  producer tag when not preloaded
- preloaded_a_value, preloaded_b_value  in  SIZE  operand values
- bus_asserted  in  BUS_COUNT  flat, per-bus valid
- bus_source  in  STATION_INDEX_SIZE*BUS_COUNT  flat tags
- bus_value  in  SIZE*BUS_COUNT  flat values
- occupied  out  1  state ≠ IDLE
- result_ready  out  1  state == DONE
- result  out  SIZE  final value; 0 unless DONE

## Operation
- FSM states: IDLE, WAIT_OPERANDS, COMPUTE, DONE.
- IDLE + set_occupied: latch op; for each operand, take the preload if given, else a matching bus value this same cycle, else record the tag. Next state is COMPUTE if both operands are held, else WAIT_OPERANDS.
- WAIT_OPERANDS: each missing operand compares its tag against all buses each cycle. On multiple matches the lowest bus index wins. Both operands may load in the same cycle. When both are held, go to COMPUTE next cycle.
- COMPUTE, first cycle: form magnitudes per signedness. MULH/DIV/REM are signed×signed, MULHSU is signed×unsigned, others unsigned. Record the result sign.
- Multiply: SIZE shift-add steps on magnitudes into a 2·SIZE accumulator; negate at the end if the signs differ. MUL returns the low half; MULH* return the high half.
- Divide: SIZE restoring steps. The quotient is negated if the signs differ. The remainder takes the dividend's sign.
- Special cases are detected in the first COMPUTE cycle and go to DONE after that single cycle:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed MIN ÷ −1: DIV returns MIN; REM returns 0.
- DONE: result held stable until release.
- reset_occupied in any state goes to IDLE next cycle and clears result.
- set_occupied in any state restarts with the new op. It takes priority over reset_occupied in the same cycle.
- Bus traffic in IDLE, COMPUTE or DONE is ignored.

## Timing
- Reset values: occupied=0, result_ready=0, result=0, FSM=IDLE.
- K = SIZE/ITERATIONS_PER_CYCLE.
- With both operands preloaded and issue at edge T: COMPUTE during T+1…T+K; result_ready=1 from T+K+1.
- Special case: result_ready from T+2.
- Late operand: if the last operand arrives on a bus at edge T', result_ready is high from T'+K+1.
- Defaults: SIZE=32, IPC=4 gives K=8.
- result_ready stays high until the cycle after reset_occupied.
- Reset asserted mid-COMPUTE: outputs drop immediately (asynchronously); no partial state survives.

## Structure
- muldiv_pkg holds:
  - the muldiv_op_t encoding;
  - helpers is_div(op), is_signed_a(op), is_signed_b(op), wants_high(op).
- The flat-array bus macros are the shared ones already in use.
- Sub-module muldiv_step: purely combinational, one multiply-or-divide iteration on {accumulator, quotient, step index}. It is instantiated ITERATIONS_PER_CYCLE times in a chain. The station owns the FSM, snooping, sign handling and the output mux.

## Test plan
- MUL 7×(−3), both preloaded, SIZE=32 IPC=4 → result 0xFFFFFFEB, result_ready exactly 9 cycles after issue.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU (−1)×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7÷2 → 0xFFFFFFFD; REM −7÷2 → 0xFFFFFFFF. DIVU 5÷0 → 0xFFFFFFFF with ready at issue+2. DIV 0x80000000÷−1 → 0x80000000.
- Issue with a_source=1 not preloaded, while bus 0 broadcasts tag 1 value 6 in the same cycle; b preloaded 4 → MUL gives 24, with no stall in WAIT_OPERANDS.
- BUS_COUNT=2, both buses match b's tag with values 9 and 11 → bus 0's value (9) is used.
- reset_occupied at COMPUTE cycle 3 → occupied=0 next cycle, result=0. Reset asserted low mid-COMPUTE → all outputs 0 at once. A following set_occupied runs cleanly.
